mem_port_mux: RTL and testbench

MEM_PORT_MUX -- requirements
Module: mem_port_mux

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_port_mux_if.sv | 32 +++
 rtl/tag_fifo.sv | 57 +++++
 rtl/mem_port_mux.sv | 126 ++++++++++++
 tb/tb_mem_port_mux.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared widths for the SDRAM port mux and its arbiter.
// Imported by mem_port_mux, its bus interface and tag_fifo.
package mem_pkg;

   localparam int MUX_COUNT       = 4;
   localparam int MEM_ADDR_W      = 24;
   localparam int MEM_DATA_W      = 32;
   localparam int MEM_MAX_PENDING = 8;

   // Tag width able to name every core, never zero bits wide.
   function automatic int tag_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_port_mux_if.sv
// Avalon-style memory bus with N parallel command lanes.
// The read-data bus is shared; readdatavalid is one strobe per lane.
interface mem_port_mux_if
   import mem_pkg::*;
#(
   parameter int N      = 1,
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
);

   localparam int BE_W = DATA_W / 8;

   logic [N*ADDR_W-1:0] address;
   logic [N-1:0]        read;
   logic [N-1:0]        write;
   logic [N*DATA_W-1:0] writedata;
   logic [N*BE_W-1:0]   byteenable;
   logic [N-1:0]        waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic [N-1:0]        readdatavalid;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata, readdatavalid
   );

endinterface

// File: rtl/tag_fifo.sv
// Tag FIFO recording which core owns each outstanding read.
// Pointers wrap modulo DEPTH (a power of two).
module tag_fifo
   import mem_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = MEM_MAX_PENDING
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   CNT_MAX = DEPTH[PTR_W:0];
   localparam logic [PTR_W:0]   CNT_ONE = 1;
   localparam logic [PTR_W-1:0] PTR_ONE = 1;

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_MAX);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = store[rd_ptr];

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) store[wr_ptr] <= din;
   end

endmodule

// File: rtl/mem_port_mux.sv
// Shares one SDRAM port among COUNT cores, routing read returns by tag.
// Define MEM_PORT_MUX_RESP_REG_EN to register the read-return outputs.
module mem_port_mux
   import mem_pkg::*;
#(
   parameter int COUNT       = MUX_COUNT,
   parameter int ADDR_W      = MEM_ADDR_W,
   parameter int DATA_W      = MEM_DATA_W,
   parameter int MAX_PENDING = MEM_MAX_PENDING
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [COUNT-1:0]             authorized,
   mem_port_mux_if.slave                core,
   mem_port_mux_if.master               mem,
   output logic [$clog2(MAX_PENDING):0] pending,
   output logic                         err_unsolicited
);

   localparam int TAG_W = tag_w(COUNT);
   localparam int BE_W  = DATA_W / 8;

   logic             sel_valid;
   logic [TAG_W-1:0] sel;
   logic             sel_read;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [TAG_W-1:0] tag;
   logic [COUNT-1:0] rdv_next;
   logic [DATA_W-1:0] rdata_next;

   // Lowest set grant bit wins; scanning downward leaves it last.
   always_comb begin
      sel_valid = 1'b0;
      sel       = '0;
      for (int i = COUNT - 1; i >= 0; i--) begin
         if (authorized[i]) begin
            sel_valid = 1'b1;
            sel       = i[TAG_W-1:0];
         end
      end
   end

   assign sel_read = sel_valid & core.read[sel];

   always_comb begin
      mem.address    = '0;
      mem.writedata  = '0;
      mem.byteenable = '0;
      if (sel_valid) begin
         mem.address    = core.address[sel*ADDR_W +: ADDR_W];
         mem.writedata  = core.writedata[sel*DATA_W +: DATA_W];
         mem.byteenable = core.byteenable[sel*BE_W +: BE_W];
      end
   end

   // Read beats write; a write presented with a read is dropped.
   assign mem.read  = sel_read & ~full;
   assign mem.write = sel_valid & core.write[sel] & ~core.read[sel];

   always_comb begin
      core.waitrequest = '1;
      if (sel_valid) begin
         core.waitrequest[sel] = mem.waitrequest[0] | (sel_read & full);
      end
   end

   assign push = mem.read[0] & ~mem.waitrequest[0];
   assign pop  = reset_n & mem.readdatavalid[0] & ~empty;

   tag_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (MAX_PENDING)
   ) u_tag_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (sel),
      .dout    (tag),
      .full    (full),
      .empty   (empty),
      .count   (pending)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         err_unsolicited <= 1'b0;
      end else if (mem.readdatavalid[0] & empty) begin
         err_unsolicited <= 1'b1;
      end
   end

   always_comb begin
      rdv_next   = '0;
      rdata_next = '0;
      if (pop) begin
         rdv_next[tag] = 1'b1;
         rdata_next    = mem.readdata;
      end
   end

`ifdef MEM_PORT_MUX_RESP_REG_EN
   logic [COUNT-1:0]  rdv_q;
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rdv_q   <= '0;
         rdata_q <= '0;
      end else begin
         rdv_q   <= rdv_next;
         rdata_q <= rdata_next;
      end
   end

   assign core.readdatavalid = rdv_q;
   assign core.readdata      = rdata_q;
`else
   assign core.readdatavalid = rdv_next;
   assign core.readdata      = rdata_next;
`endif

endmodule

// File: tb/tb_mem_port_mux.sv
// Directed bench for mem_port_mux with a tag scoreboard.
// Expected return latency follows MEM_PORT_MUX_RESP_REG_EN.
module tb_mem_port_mux;

   localparam int COUNT  = 4;
   localparam int ADDR_W = 24;
   localparam int DATA_W = 32;
   localparam int MAXP   = 8;

   logic             clock = 1'b0;
   logic             reset_n;
   logic [COUNT-1:0] authorized;
   logic [3:0]       pending;
   logic             err;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   mem_port_mux_if #(.N(COUNT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) cb ();
   mem_port_mux_if #(.N(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) mb ();

   mem_port_mux #(
      .COUNT       (COUNT),
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .MAX_PENDING (MAXP)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .authorized      (authorized),
      .core            (cb),
      .mem             (mb),
      .pending         (pending),
      .err_unsolicited (err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue_read(input int c, input logic [ADDR_W-1:0] a);
      cb.read[c] = 1'b1;
      cb.address[c*ADDR_W +: ADDR_W] = a;
      #1;
      chk("rd_mem_read", mb.read, 1);
      chk("rd_mem_addr", mb.address, a);
      chk("rd_core_wait", cb.waitrequest[c], 0);
      exp_q.push_back(c);
      tick();
      cb.read[c] = 1'b0;
   endtask

   task automatic ret(input logic [DATA_W-1:0] data, input bit full_chk);
      logic [COUNT-1:0] ev;
      bit has;
      has = (exp_q.size() != 0);
      ev = '0;
      if (has) ev[exp_q.pop_front()] = 1'b1;
      mb.readdatavalid = 1'b1;
      mb.readdata = data;
      #1;
      if (full_chk) chk("full_blocks_read", mb.read, 0);
`ifdef MEM_PORT_MUX_RESP_REG_EN
      chk("resp_not_yet", cb.readdatavalid, 0);
      tick();
      mb.readdatavalid = 1'b0;
      mb.readdata = '0;
      #1;
      chk("resp_valid", cb.readdatavalid, ev);
      chk("resp_data", cb.readdata, has ? data : '0);
`else
      chk("resp_valid", cb.readdatavalid, ev);
      chk("resp_data", cb.readdata, has ? data : '0);
      tick();
      mb.readdatavalid = 1'b0;
      mb.readdata = '0;
      #1;
      chk("resp_clear", cb.readdatavalid, 0);
`endif
   endtask

   initial begin
      reset_n = 1'b0;
      authorized = '0;
      cb.read = '0;
      cb.write = '0;
      cb.address = '0;
      cb.writedata = '0;
      cb.byteenable = '0;
      mb.waitrequest = '0;
      mb.readdata = '0;
      mb.readdatavalid = '0;
      tick();
      tick();
      chk("rst_pending", pending, 0);
      chk("rst_err", err, 0);
      chk("rst_rdv", cb.readdatavalid, 0);
      chk("rst_rdata", cb.readdata, 0);
      chk("rst_mem_read", mb.read, 0);
      chk("rst_mem_write", mb.write, 0);
      chk("rst_wait", cb.waitrequest, 4'hF);
      chk("rst_addr", mb.address, 0);
      reset_n = 1'b1;
      tick();

      // core 2 reads, return three cycles after acceptance
      authorized = 4'b0100;
      issue_read(2, 24'h001234);
      chk("t1_pending", pending, 1);
      authorized = '0;
      tick();
      tick();
      ret(32'hDEADBEEF, 1'b0);
      chk("t1_pending0", pending, 0);

      // lowest grant bit selects, write path, stall behaviour
      authorized = 4'b1010;
      cb.write[1] = 1'b1;
      cb.write[3] = 1'b1;
      cb.address[1*ADDR_W +: ADDR_W] = 24'h00ABCD;
      cb.address[3*ADDR_W +: ADDR_W] = 24'h00FFFF;
      cb.writedata[1*DATA_W +: DATA_W] = 32'hCAFEF00D;
      cb.writedata[3*DATA_W +: DATA_W] = 32'h11111111;
      cb.byteenable[4 +: 4] = 4'b0110;
      cb.byteenable[12 +: 4] = 4'b1111;
      #1;
      chk("wr_mem_write", mb.write, 1);
      chk("wr_mem_read", mb.read, 0);
      chk("wr_addr", mb.address, 24'h00ABCD);
      chk("wr_data", mb.writedata, 32'hCAFEF00D);
      chk("wr_be", mb.byteenable, 4'b0110);
      chk("wr_wait_vec", cb.waitrequest, 4'b1101);
      mb.waitrequest = 1'b1;
      #1;
      chk("wr_wait_stall", cb.waitrequest, 4'b1111);
      mb.waitrequest = 1'b0;
      cb.read[1] = 1'b1;
      #1;
      chk("rw_mem_read", mb.read, 1);
      chk("rw_mem_write", mb.write, 0);
      exp_q.push_back(1);
      tick();
      cb.read[1] = 1'b0;
      cb.write = '0;
      authorized = '0;
      #1;
      chk("rw_pending", pending, 1);
      chk("idle_mem_write", mb.write, 0);
      ret(32'h5555AAAA, 1'b0);

      // a stalled read is not counted
      authorized = 4'b0001;
      cb.read[0] = 1'b1;
      mb.waitrequest = 1'b1;
      #1;
      chk("stall_mem_read", mb.read, 1);
      tick();
      chk("stall_pending", pending, 0);
      mb.waitrequest = 1'b0;
      cb.read[0] = 1'b0;

      // grant switch with reads in flight
      issue_read(0, 24'h000010);
      issue_read(0, 24'h000011);
      authorized = 4'b1000;
      issue_read(3, 24'h000030);
      chk("sw_pending3", pending, 3);
      authorized = '0;
      ret(32'hA0A0A0A0, 1'b0);
      chk("sw_pending2", pending, 2);
      ret(32'hB1B1B1B1, 1'b0);
      chk("sw_pending1", pending, 1);
      ret(32'hC3C3C3C3, 1'b0);
      chk("sw_pending0", pending, 0);

      // fill to MAX_PENDING, ninth read waits for a return
      authorized = 4'b0001;
      for (int i = 0; i < MAXP; i++) issue_read(0, 24'h000100 + 24'(i));
      chk("full_pending", pending, MAXP);
      cb.read[0] = 1'b1;
      #1;
      chk("full_wait", cb.waitrequest[0], 1);
      chk("full_mem_read", mb.read, 0);
      tick();
      chk("full_hold", pending, MAXP);
      ret(32'h00001000, 1'b1);
      chk("full_after_pop", pending, MAXP - 1);
      chk("ninth_mem_read", mb.read, 1);
      chk("ninth_wait", cb.waitrequest[0], 0);
      exp_q.push_back(0);
      tick();
      cb.read[0] = 1'b0;
      authorized = '0;
      chk("ninth_pending", pending, MAXP);
      for (int i = 0; i < MAXP; i++) ret(32'h00002000 + 32'(i), 1'b0);
      chk("drain_pending", pending, 0);
      chk("no_err_yet", err, 0);

      // unsolicited return
      ret(32'h00000BAD, 1'b0);
      chk("unsol_err", err, 1);
      tick();
      tick();
      chk("unsol_sticky", err, 1);
      reset_n = 1'b0;
      tick();
      chk("unsol_rst", err, 0);
      reset_n = 1'b1;
      tick();

      // reset with reads in flight
      authorized = 4'b0100;
      for (int i = 0; i < 3; i++) issue_read(2, 24'h000200 + 24'(i));
      authorized = '0;
      chk("mid_pending3", pending, 3);
      reset_n = 1'b0;
      tick();
      chk("mid_pending0", pending, 0);
      chk("mid_rdv", cb.readdatavalid, 0);
      reset_n = 1'b1;
      exp_q.delete();
      tick();
      chk("mid_err0", err, 0);
      for (int i = 0; i < 3; i++) ret(32'h00007000 + 32'(i), 1'b0);
      chk("late_err", err, 1);
      chk("late_pending", pending, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
